// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared MAC widths, feeder state encoding and length check
package mac_pkg;

  localparam int MAC_WIDTH     = 14;
  localparam int MAC_ACC_WIDTH = 28;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } feeder_state_t;

  function automatic logic len_legal(input int len, input int depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/mac_operand_ram.sv
// rtl/mac_operand_ram.sv - operand regfile, one sync write port, one async read port
module mac_operand_ram #(
  parameter int WIDTH  = 14,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // Contents are deliberately left unreset; only control state is reset.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - streams stored operand pairs into the MAC after a one-cycle clear
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int  WIDTH  = MAC_WIDTH,
  parameter int  DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [ADDR_W:0]         len,
  input  logic                    start,
  input  logic                    stall,
  output logic                    mac_clr,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err
);

  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  feeder_state_t     state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last_q;
  logic [WIDTH-1:0]  rd_a;
  logic [WIDTH-1:0]  rd_b;
  logic              wr_ok;

  // The DONE cycle is spent in IDLE with busy still high, so gate on both.
  assign wr_ok = (state == IDLE) && !busy;

  mac_operand_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_a (
    .clk     (clk),
    .we      (wr_en && wr_ok && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_a)
  );

  mac_operand_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram_b (
    .clk     (clk),
    .we      (wr_en && wr_ok && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (rd_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      last_q    <= '0;
      mac_clr   <= 1'b0;
      a         <= '0;
      b         <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      mac_clr   <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            if (len_legal(int'(len), DEPTH)) begin
              last_q  <= ADDR_W'(len - LEN_ONE);
              idx     <= '0;
              mac_clr <= 1'b1;
              busy    <= 1'b1;
              state   <= CLEAR;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        // CLEAR issues the first beat on its exit edge so beat 0 lands right after the clear.
        CLEAR, STREAM: begin
          if (state == CLEAR) begin
            state <= STREAM;
          end
          if (!stall) begin
            a         <= rd_a;
            b         <= rd_b;
            valid_out <= 1'b1;
            idx       <= idx + IDX_ONE;
            if (idx == last_q) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
